motor_cmd_cond: RTL
===================

MOTOR_CMD_COND -- requirements
Module: motor_cmd_cond

Interface
REQ-001 Parameter CH_NUM, default 7: number of independent command input channels.
REQ-002 Parameter SYNC_STAGES, default 2 (legal 2..4): synchroniser flop depth per channel.
REQ-003 Parameter DEB_LIMIT, default 10000 (1 ms at 10 MHz): consecutive stable cycles required to accept a new level.
REQ-004 Parameter REP_DELAY, default 5000000: held-high cycles before the first auto-repeat pulse.
REQ-005 Parameter REP_RATE, default 1000000: cycles between subsequent auto-repeat pulses.
REQ-006 clkI  input  1  sole clock, 10 MHz.
REQ-007 nRstI  input  1  reset, asynchronous assert, active-low.
REQ-008 rawI  input  CH_NUM  asynchronous raw command levels (start, forceStop, invRotate, freq/power INC/DEC, ...).
REQ-009 repMaskI  input  CH_NUM  per-channel auto-repeat enable, quasi-static.
REQ-010 levelO  output  CH_NUM  debounced command level.
REQ-011 riseO  output  CH_NUM  one-cycle pulse on accepted 0->1.
REQ-012 fallO  output  CH_NUM  one-cycle pulse on accepted 1->0.
REQ-013 repO  output  CH_NUM  one-cycle auto-repeat pulse.

Function
REQ-014 Each channel SHALL pass rawI through SYNC_STAGES flops before any other use; channels SHALL be fully independent.
REQ-015 Debounce counter SHALL be ceil(log2(DEB_LIMIT+1)) bits and SHALL increment each cycle the synchronised value differs from levelO.
REQ-016 Counter SHALL clear in the cycle the synchronised value equals levelO again (glitch rejected, no output change).
REQ-017 When counter equals DEB_LIMIT-1 and the value still differs, next edge SHALL update levelO, clear the counter and assert riseO or fallO for exactly one cycle.
REQ-018 Raw-to-levelO latency for a clean step SHALL be exactly SYNC_STAGES+DEB_LIMIT cycles.
REQ-019 Repeat state machine per channel: R_IDLE, R_DELAY, R_RATE.
REQ-020 R_IDLE -> R_DELAY on riseO while repMaskI bit set; repeat counter cleared.
REQ-021 R_DELAY -> R_RATE when counter reaches REP_DELAY-1; repO pulses that cycle; counter cleared.
REQ-022 R_RATE SHALL pulse repO and clear the counter every REP_RATE cycles.
REQ-023 Any state -> R_IDLE when levelO is 0 or repMaskI bit is 0; no repO in that cycle.
REQ-024 riseO and repO SHALL never assert in the same cycle on one channel; first repO is REP_DELAY cycles after riseO.
REQ-025 Repeat counter width SHALL cover max(REP_DELAY,REP_RATE); no wrap-around permitted.

Reset
REQ-026 On nRstI low all synchroniser flops, counters, levelO, riseO, fallO, repO SHALL be 0 and FSMs R_IDLE, asynchronously.
REQ-027 Reset mid-debounce or mid-repeat SHALL abort without emitting any pulse; after release a raw level already high SHALL produce a normal riseO after SYNC_STAGES+DEB_LIMIT cycles.

Configuration
REQ-028 Macro MOTOR_CMD_AUTOREPEAT_EN defined: repeat FSM and counters SHALL be built per REQ-019..025.
REQ-029 Macro undefined: repO SHALL be tied to 0, repMaskI ignored, no repeat logic synthesised; debounce unchanged.

Structure
REQ-030 Package motor_cmd_pkg SHALL hold the repeat-state enumeration, default parameter constants and a clog2-style width function.
REQ-031 One sub-module motor_cmd_chan (sync + debounce + repeat for one channel) SHALL be instantiated CH_NUM times by generate.

Verification (CH_NUM=7, SYNC_STAGES=2, DEB_LIMIT=4, REP_DELAY=8, REP_RATE=3, macro defined)
REQ-032 rawI[6] 0->1 at cycle 0, held -> levelO[6]=1 and riseO[6] pulse at cycle 6; no other channel toggles.
REQ-033 rawI[3] high for 3 cycles then low -> no levelO/riseO/fallO change on any channel.
REQ-034 repMaskI[3]=1, rawI[3] held high -> riseO at cycle 6, repO at cycles 14, 17, 20; release -> fallO 6 cycles after raw falls, repO stops immediately.
REQ-035 repMaskI[3] cleared during R_RATE -> no further repO while level stays high.
REQ-036 nRstI low at cycle 4 of a debounce, rawI held high -> all outputs 0 during reset; riseO 6 cycles after release.
REQ-037 Build without MOTOR_CMD_AUTOREPEAT_EN, rerun REQ-034 stimulus -> repO constant 0, riseO/fallO timing identical.

Source files
------------

// File: rtl/motor_cmd_pkg.sv
// Shared types and defaults for the motor command conditioner.
// Repeat-state encoding, default parameters and a counter-width helper.
package motor_cmd_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_RATE
    } rep_state_e;

    localparam int DEF_CH_NUM      = 7;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_LIMIT   = 10000;
    localparam int DEF_REP_DELAY   = 5000000;
    localparam int DEF_REP_RATE    = 1000000;

    // Bits needed to hold 0..v, i.e. ceil(log2(v+1)), never below 1.
    function automatic int cnt_width(input int unsigned v);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(v)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/motor_cmd_cond_if.sv
// Command bundle between the raw panel inputs and the conditioned outputs.
// The controller side drives raw levels and masks; the conditioner answers.
interface motor_cmd_cond_if
    import motor_cmd_pkg::*;
#(
    parameter int CH_NUM = DEF_CH_NUM
);

    logic [CH_NUM-1:0] rawI;
    logic [CH_NUM-1:0] repMaskI;
    logic [CH_NUM-1:0] levelO;
    logic [CH_NUM-1:0] riseO;
    logic [CH_NUM-1:0] fallO;
    logic [CH_NUM-1:0] repO;

    modport master (
        output rawI,
        output repMaskI,
        input  levelO,
        input  riseO,
        input  fallO,
        input  repO
    );

    modport slave (
        input  rawI,
        input  repMaskI,
        output levelO,
        output riseO,
        output fallO,
        output repO
    );

endinterface

// File: rtl/motor_cmd_chan.sv
// One command channel: synchroniser, debouncer and optional auto-repeat.
// Auto-repeat is built only when MOTOR_CMD_AUTOREPEAT_EN is defined.
module motor_cmd_chan
    import motor_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_LIMIT   = DEF_DEB_LIMIT,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_RATE    = DEF_REP_RATE
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic rawI,
    input  logic repMaskI,
    output logic levelO,
    output logic riseO,
    output logic fallO,
    output logic repO
);

    localparam int DW = cnt_width(DEB_LIMIT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_v;
    logic                   diff;
    logic                   accept;

    assign sync_v = sync_q[SYNC_STAGES-1];

    always_comb begin
        diff    = sync_v ^ level_q;
        accept  = diff && (cnt_q == DW'(DEB_LIMIT - 1));
        cnt_d   = '0;
        if (diff && !accept) begin
            cnt_d = cnt_q + 1'b1;
        end
        level_d = level_q ^ accept;
        rise_d  = accept & ~level_q;
        fall_d  = accept & level_q;
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rawI};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign levelO = level_q;
    assign riseO  = rise_q;
    assign fallO  = fall_q;

`ifdef MOTOR_CMD_AUTOREPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = cnt_width(RMAX);

    rep_state_e    state_q;
    logic [RW-1:0] rcnt_q;
    logic          rep_q;

    // Arm on the same edge riseO is raised so the first repeat lands
    // exactly REP_DELAY cycles after it; abort if the level is dropping.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q <= R_IDLE;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else if (rise_d && repMaskI) begin
            state_q <= R_DELAY;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else if (!level_d || !repMaskI) begin
            state_q <= R_IDLE;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else begin
            unique case (state_q)
                R_DELAY: begin
                    if (rcnt_q == RW'(REP_DELAY - 1)) begin
                        state_q <= R_RATE;
                        rcnt_q  <= '0;
                        rep_q   <= 1'b1;
                    end else begin
                        rcnt_q  <= rcnt_q + 1'b1;
                        rep_q   <= 1'b0;
                    end
                end
                R_RATE: begin
                    if (rcnt_q == RW'(REP_RATE - 1)) begin
                        rcnt_q  <= '0;
                        rep_q   <= 1'b1;
                    end else begin
                        rcnt_q  <= rcnt_q + 1'b1;
                        rep_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                    rcnt_q  <= '0;
                    rep_q   <= 1'b0;
                end
            endcase
        end
    end

    assign repO = rep_q;
`else
    logic unused_rep_mask;
    assign unused_rep_mask = repMaskI;
    assign repO            = 1'b0;
`endif

endmodule

// File: rtl/motor_cmd_cond.sv
// Motor command input conditioner: CH_NUM independent channels.
// Define MOTOR_CMD_AUTOREPEAT_EN to build per-channel auto-repeat.
module motor_cmd_cond
    import motor_cmd_pkg::*;
#(
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_LIMIT   = DEF_DEB_LIMIT,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_RATE    = DEF_REP_RATE
) (
    input  logic             clkI,
    input  logic             nRstI,
    motor_cmd_cond_if.slave  bus
);

    logic [CH_NUM-1:0] level;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic [CH_NUM-1:0] rep;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        motor_cmd_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_LIMIT   (DEB_LIMIT),
            .REP_DELAY   (REP_DELAY),
            .REP_RATE    (REP_RATE)
        ) u_chan (
            .clkI     (clkI),
            .nRstI    (nRstI),
            .rawI     (bus.rawI[g]),
            .repMaskI (bus.repMaskI[g]),
            .levelO   (level[g]),
            .riseO    (rise[g]),
            .fallO    (fall[g]),
            .repO     (rep[g])
        );
    end

    assign bus.levelO = level;
    assign bus.riseO  = rise;
    assign bus.fallO  = fall;
    assign bus.repO   = rep;

endmodule
